// File: rtl/rv32_branch_predictor_pkg.sv
// Shared types for the RV32 branch predictor: data width, default table
// size, 2-bit direction counter encodings and the per-entry record.
package pkg_rv32_types;

    localparam int XLEN               = 32;
    localparam int BP_ENTRIES_DEFAULT = 16;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } bp_ctr_t;

    // Tag is kept at full XLEN width so the record does not depend on the
    // table size; bits above the real tag width are always zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        bp_ctr_t         ctr;
    } bp_entry_t;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        case (ctr)
            CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
            CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
            default:       nxt = CTR_WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rv32_branch_predictor_if.sv
// Lookup, update and result bundle of the branch predictor. The fetch/execute
// side drives through 'master'; the predictor connects through 'slave'.
interface rv32_branch_predictor_if;
    import pkg_rv32_types::*;

    logic [XLEN-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic            update_pred_taken;
    logic [XLEN-1:0] update_pred_target;

    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output lookup_pc, update_valid, update_pc, update_taken, update_target,
               update_pred_taken, update_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, update_valid, update_pc, update_taken, update_target,
               update_pred_taken, update_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with a 2-bit direction
// counter and a taken target. Lookup is combinational against the current
// table; updates land on the clock edge, so a same-cycle lookup sees the
// pre-update contents. Mispredict/redirect and statistics are registered.
module rv32_branch_predictor
    import pkg_rv32_types::*;
#(
    parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    rv32_branch_predictor_if.slave  bp
);

    localparam int IDX_W = $clog2(BP_ENTRIES);

    bp_entry_t       table_r [BP_ENTRIES];
    logic            mispredict_r;
    logic [XLEN-1:0] redirect_r;
    logic [31:0]     branch_cnt_r;
    logic [31:0]     mispredict_cnt_r;

    logic [IDX_W-1:0] lk_idx_s;
    logic [XLEN-1:0]  lk_tag_s;
    bp_entry_t        lk_entry_s;
    logic             lk_hit_s;
    logic             lk_taken_s;
    logic [XLEN-1:0]  lk_target_s;

    logic [IDX_W-1:0] up_idx_s;
    logic [XLEN-1:0]  up_tag_s;
    bp_entry_t        up_entry_s;
    bp_entry_t        up_next_s;
    logic             up_hit_s;
    logic             up_wr_s;
    logic [XLEN-1:0]  correct_npc_s;
    logic             mp_s;

    assign lk_idx_s = bp.lookup_pc[IDX_W+1:2];
    assign lk_tag_s = {{(IDX_W+2){1'b0}}, bp.lookup_pc[XLEN-1:IDX_W+2]};
    assign up_idx_s = bp.update_pc[IDX_W+1:2];
    assign up_tag_s = {{(IDX_W+2){1'b0}}, bp.update_pc[XLEN-1:IDX_W+2]};

    // Zero-latency prediction from the current (pre-update) table.
    always_comb begin
        lk_entry_s = table_r[lk_idx_s];
        lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
        lk_taken_s = lk_hit_s && lk_entry_s.ctr[1];
        if (lk_taken_s) begin
            lk_target_s = lk_entry_s.target;
        end else begin
            lk_target_s = bp.lookup_pc + 32'd4;
        end
    end

    // Next entry contents for a resolved branch: train on hit, allocate on a
    // taken miss, leave the slot alone on a not-taken miss.
    always_comb begin
        up_entry_s = table_r[up_idx_s];
        up_next_s  = up_entry_s;
        up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
        up_wr_s    = 1'b0;
        if (bp.update_valid) begin
            if (up_hit_s) begin
                up_wr_s       = 1'b1;
                up_next_s.ctr = ctr_next(up_entry_s.ctr, bp.update_taken);
                if (bp.update_taken) begin
                    up_next_s.target = bp.update_target;
                end else begin
                    up_next_s.target = up_entry_s.target;
                end
            end else if (bp.update_taken) begin
                up_wr_s   = 1'b1;
                up_next_s = '{valid: 1'b1, tag: up_tag_s,
                              target: bp.update_target, ctr: CTR_WEAK_T};
            end else begin
                up_wr_s = 1'b0;
            end
        end else begin
            up_wr_s = 1'b0;
        end
    end

    // Architecturally correct next PC and the mispredict decision.
    always_comb begin
        if (bp.update_taken) begin
            correct_npc_s = bp.update_target;
        end else begin
            correct_npc_s = bp.update_pc + 32'd4;
        end
        mp_s = (correct_npc_s != bp.update_pred_target) ||
               (bp.update_taken != bp.update_pred_taken);
    end

    // Table, flush pulse, redirect and statistics; reset wins over updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                table_r[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
            mispredict_r     <= 1'b0;
            redirect_r       <= '0;
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else begin
            if (up_wr_s) begin
                table_r[up_idx_s] <= up_next_s;
            end
            mispredict_r <= bp.update_valid && mp_s;
            if (bp.update_valid) begin
                redirect_r <= correct_npc_s;
            end
            if (bp.update_valid && (branch_cnt_r != 32'hFFFF_FFFF)) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
            if (bp.update_valid && mp_s && (mispredict_cnt_r != 32'hFFFF_FFFF)) begin
                mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
            end
        end
    end

    assign bp.pred_hit         = lk_hit_s;
    assign bp.pred_taken       = lk_taken_s;
    assign bp.pred_target      = lk_target_s;
    assign bp.mispredict       = mispredict_r;
    assign bp.redirect_pc      = redirect_r;
    assign bp.branch_count     = branch_cnt_r;
    assign bp.mispredict_count = mispredict_cnt_r;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Scoreboard bench for rv32_branch_predictor: directed scenarios followed by
// randomized traffic, checked against a simple array-based predictor model.
module tb_rv32_branch_predictor;
    import pkg_rv32_types::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32_branch_predictor_if bif();

    rv32_branch_predictor #(.BP_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } lk_exp_t;

    typedef struct {
        logic        mp;
        logic        chk_redir;
        logic [31:0] redir;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } rg_exp_t;

    lk_exp_t lk_q[$];
    rg_exp_t rg_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain arrays indexed by (pc/4) mod N, tag = pc/(4N).
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_target[N];
    int          m_ctr   [N];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_ctr[i] = 1;
        end
        m_bcnt = 32'd0;
        m_mcnt = 32'd0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic hit,
                                 output logic taken, output logic [31:0] target);
        int idx;
        idx    = int'((pc / 32'd4) % N);
        hit    = m_valid[idx] && (m_tag[idx] == pc / (4 * N));
        taken  = hit && (m_ctr[idx] >= 2);
        target = taken ? m_target[idx] : pc + 32'd4;
    endtask

    // One clock of stimulus; expectations are queued for the monitors.
    task automatic cycle(input logic r, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic upt, input logic [31:0] uptgt);
        lk_exp_t le;
        rg_exp_t re;
        logic [31:0] correct;
        logic mp;
        int idx;
        @(negedge clk);
        rst = r;
        bif.lookup_pc = lpc;
        bif.update_valid = uv;
        bif.update_pc = upc;
        bif.update_taken = ut;
        bif.update_target = utgt;
        bif.update_pred_taken = upt;
        bif.update_pred_target = uptgt;
        le.pc = lpc;
        model_predict(lpc, le.hit, le.taken, le.target);
        lk_q.push_back(le);
        re = '{mp: 1'b0, chk_redir: 1'b0, redir: 32'd0, bcnt: 32'd0, mcnt: 32'd0};
        if (r) begin
            model_reset();
            re.chk_redir = 1'b1;
        end else if (uv) begin
            correct = ut ? utgt : upc + 32'd4;
            mp = (correct != uptgt) || (ut != upt);
            idx = int'((upc / 32'd4) % N);
            if (m_valid[idx] && m_tag[idx] == upc / (4 * N)) begin
                m_ctr[idx] = ut ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                if (ut) m_target[idx] = utgt;
            end else if (ut) begin
                m_valid[idx] = 1'b1; m_tag[idx] = upc / (4 * N);
                m_target[idx] = utgt; m_ctr[idx] = 2;
            end
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (mp && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
            re.mp = mp;
            re.chk_redir = mp;
            re.redir = correct;
        end
        re.bcnt = m_bcnt;
        re.mcnt = m_mcnt;
        rg_q.push_back(re);
    endtask

    task automatic idle(input logic [31:0] lpc);
        cycle(1'b0, lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tagv;
        int sel;
        sel  = $urandom_range(0, 4);
        tagv = (sel == 4) ? 32'h03FF_FFFF : 32'(sel);
        return tagv * 32'(4 * N) + 32'($urandom_range(0, N - 1)) * 32'd4;
    endfunction

    // Monitor: combinational prediction, sampled mid-low-phase.
    initial begin
        lk_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (lk_q.size() > 0) begin
                e = lk_q.pop_front();
                check("pred_hit", {31'd0, bif.pred_hit}, {31'd0, e.hit});
                check("pred_taken", {31'd0, bif.pred_taken}, {31'd0, e.taken});
                check("pred_target", bif.pred_target, e.target);
            end
        end
    end

    // Monitor: registered flush, redirect and statistics after each edge.
    initial begin
        rg_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rg_q.size() > 0) begin
                e = rg_q.pop_front();
                check("mispredict", {31'd0, bif.mispredict}, {31'd0, e.mp});
                if (e.chk_redir) check("redirect_pc", bif.redirect_pc, e.redir);
                check("branch_count", bif.branch_count, e.bcnt);
                check("mispredict_count", bif.mispredict_count, e.mcnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h, t;
        logic [31:0] pt, lpc, upc, utgt, uptgt;
        logic uv, ut, upt, r;
        bif.lookup_pc = 32'd0; bif.update_valid = 1'b0; bif.update_pc = 32'd0;
        bif.update_taken = 1'b0; bif.update_target = 32'd0;
        bif.update_pred_taken = 1'b0; bif.update_pred_target = 32'd0;
        model_reset();

        // Reset, then an empty lookup.
        cycle(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(32'h100);
        // First taken branch allocates and mispredicts.
        cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        idle(32'h100);
        // Train to strong taken, then two not-taken steps.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        idle(32'h100);
        // Not-taken miss does not allocate.
        cycle(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
        idle(32'h300);
        // Aliasing replacement at index 0.
        cycle(1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 32'h480, 1'b0, 32'h144);
        idle(32'h100);
        idle(32'h140);
        // Same-cycle lookup/update, then reset during the flush cycle.
        cycle(1'b0, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h480);
        cycle(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h900, 1'b0, 32'h144);
        idle(32'h140);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            lpc = rand_pc();
            uv  = ($urandom_range(0, 3) != 0);
            upc = rand_pc();
            ut  = $urandom_range(0, 1);
            utgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                model_predict(upc, h, t, pt);
                upt = t; uptgt = pt;
            end else begin
                upt = $urandom_range(0, 1);
                uptgt = ($urandom_range(0, 1) == 1) ? upc + 32'd4 : utgt;
            end
            cycle(r, lpc, uv, upc, ut, utgt, upt, uptgt);
        end

        idle(32'h0);
        idle(32'h0);
        @(posedge clk);
        #3;
        n_cmp++;
        if (lk_q.size() != 0 || rg_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0", lk_q.size(), rg_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
